accum_array: RTL and testbench
==============================

# accum_array

Parametrised multi-lane accumulator, next generation of the fixed four-lane accumulator used in the integration-test models. Each of NUM_LANES lanes holds an ACCUM_WIDTH accumulator that is updated by a per-lane operand under a shared opcode and a lane mask. Every update uses a req/done four-phase handshake with the test harness. The block adds subtract, load and clear modes, optional saturation, sticky per-lane overflow flags and a completed-operation counter.

## Interface
- NUM_LANES, 4, number of independent accumulator lanes (≥1)
- ACCUM_WIDTH, 32, accumulator width per lane
- ADD_WIDTH, 16, operand width per lane (1 ≤ ADD_WIDTH ≤ ACCUM_WIDTH)
- SATURATE, 0, 0 = wrap on overflow/underflow; 1 = clamp
- clk  in  1  single clock, all state on rising edge
- reset_l  in  1  asynchronous, active-low reset
- req  in  1  operation request, four-phase handshake
- op  in  2  opcode: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
- lane_mask  in  NUM_LANES  bit i = 1 selects lane i for the operation
- operand  in  ADD_WIDTH × [NUM_LANES]  per-lane operand, unpacked array
- accum  out  ACCUM_WIDTH × [NUM_LANES]  current accumulator values, unpacked array
- ovf  out  NUM_LANES  sticky overflow/underflow flag per lane
- busy  out  1  high in EXEC and DONE
- done  out  1  operation complete, held until req drops
- op_count  out  16  count of completed operations, wraps

## Operation
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE: when req = 1, capture op, lane_mask and all operands into holding registers, then go to EXEC. Inputs are ignored outside IDLE.
- EXEC: apply the captured op to each masked lane, then go to DONE unconditionally. Unmasked lanes and their ovf bits are unchanged.
- DONE: done = 1. Stay while req = 1. When req = 0, go to IDLE.
- Operands are zero-extended to ACCUM_WIDTH.
- ADD: compute accum + operand as unsigned with one carry bit. On carry out, set ovf[i]. The result is the truncated sum when SATURATE = 0, or all ones when SATURATE = 1.
- SUB: compute accum − operand as unsigned. On borrow, set ovf[i]. The result is the truncated difference when SATURATE = 0, or 0 when SATURATE = 1.
- LOAD: accum = operand (zero-extended); ovf[i] cleared.
- CLEAR: accum = 0; ovf[i] cleared.
- ovf is sticky. It clears only by LOAD or CLEAR on that lane, or by reset.
- op_count increments by 1 on the EXEC→DONE transition, including when lane_mask = 0. It wraps from 0xFFFF to 0.
- lane_mask = 0 is legal. It is a full handshake with no lane change.

## Timing
- Reset values: accum all 0, ovf 0, busy 0, done 0, op_count 0, FSM in IDLE.
- Reset acts immediately on assertion, regardless of state. Any in-flight operation is discarded.
- Cycle N: req sampled high in IDLE. Cycle N+1: busy = 1, state is EXEC.
- Edge ending N+1: accum, ovf and op_count update. Cycle N+2: done = 1 and the new values are visible.
- Request-to-done latency is 2 cycles.
- done falls one cycle after req is sampled low in DONE.
- busy falls together with done.
- req dropping during EXEC does not abort. DONE is still entered and done is high for exactly 1 cycle.
- A new req is accepted only from IDLE. Back-to-back operations take at least 4 cycles each: IDLE, EXEC, DONE, then req low.
- accum and ovf are registered outputs and are stable outside the EXEC→DONE edge.

## Test plan
- Reset values: assert reset_l = 0 mid-stream, release. Required: accum all 0, ovf = 0, done = 0, busy = 0, op_count = 0.
- Basic ADD (defaults): ADD with mask 0xF, operands {1, 2, 3, 0xFFFF}, done at +2 cycles; repeat. Required: accum = {2, 4, 6, 0x1FFFE}, op_count = 2, ovf = 0.
- Mask and LOAD: LOAD with mask 0x5, operands {0x10, 0x20, 0x30, 0x40} after the basic ADD scenario. Required: accum = {0x10, 4, 0x30, 0x1FFFE}.
- Wrap vs saturate (ACCUM_WIDTH = ADD_WIDTH = 16): LOAD 0xFFF0 then ADD 0x0020.
  - SATURATE = 0: accum = 0x0010, ovf[0] = 1.
  - SATURATE = 1: accum = 0xFFFF.
  - SUB 0x0001 from 0: result 0xFFFF (wrap) or 0 (saturate), ovf set in both cases.
  - A following CLEAR clears ovf.
- Handshake: hold req high 5 cycles past done. Required: done high the whole time, no second update.
- Handshake, early drop: drop req during EXEC. Required: a 1-cycle done pulse and a single update.
- Reset mid-op: assert reset_l low during EXEC. Required: immediate return to the reset values, no update applied, op_count = 0.

Source files
------------

// File: rtl/accum_array.sv
// Multi-lane accumulator. A four-phase req/done handshake applies one shared opcode
// to every lane selected by the mask, with optional clamping and sticky overflow flags.
module accum_array #(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned ACCUM_WIDTH = 32,
  parameter int unsigned ADD_WIDTH   = 16,
  parameter int unsigned SATURATE    = 0
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   req,
  input  logic [1:0]             op,
  input  logic [NUM_LANES-1:0]   lane_mask,
  input  logic [ADD_WIDTH-1:0]   operand [NUM_LANES],
  output logic [ACCUM_WIDTH-1:0] accum   [NUM_LANES],
  output logic [NUM_LANES-1:0]   ovf,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            op_count
);

  localparam int unsigned EXT_W = ACCUM_WIDTH + 1;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [1:0]             r_op;
  logic [NUM_LANES-1:0]   r_mask;
  logic [ADD_WIDTH-1:0]   r_operand   [NUM_LANES];
  logic [ACCUM_WIDTH-1:0] r_accum     [NUM_LANES];
  logic [NUM_LANES-1:0]   r_ovf;
  logic                   r_busy;
  logic                   r_done;
  logic [15:0]            r_op_count;

  logic [EXT_W-1:0]       w_sum       [NUM_LANES];
  logic [EXT_W-1:0]       w_diff      [NUM_LANES];
  logic [ACCUM_WIDTH-1:0] w_accum_nxt [NUM_LANES];
  logic [NUM_LANES-1:0]   w_ovf_nxt;

  // State register
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_DONE;
      S_DONE:  if (!req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture; inputs are only looked at in IDLE
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_op   <= OP_ADD;
      r_mask <= '0;
      for (int i = 0; i < NUM_LANES; i++) r_operand[i] <= '0;
    end else if (r_state == S_IDLE && req) begin
      r_op   <= op;
      r_mask <= lane_mask;
      for (int i = 0; i < NUM_LANES; i++) r_operand[i] <= operand[i];
    end
  end

  // Per-lane result; the extra top bit is the carry (ADD) or borrow (SUB)
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      w_sum[i]       = {1'b0, r_accum[i]} + EXT_W'(r_operand[i]);
      w_diff[i]      = {1'b0, r_accum[i]} - EXT_W'(r_operand[i]);
      w_accum_nxt[i] = r_accum[i];
      w_ovf_nxt[i]   = r_ovf[i];
      if (r_mask[i]) begin
        case (r_op)
          OP_ADD: begin
            w_accum_nxt[i] = w_sum[i][ACCUM_WIDTH-1:0];
            if (w_sum[i][ACCUM_WIDTH]) begin
              w_ovf_nxt[i] = 1'b1;
              if (SATURATE != 0) w_accum_nxt[i] = '1;
            end
          end
          OP_SUB: begin
            w_accum_nxt[i] = w_diff[i][ACCUM_WIDTH-1:0];
            if (w_diff[i][ACCUM_WIDTH]) begin
              w_ovf_nxt[i] = 1'b1;
              if (SATURATE != 0) w_accum_nxt[i] = '0;
            end
          end
          OP_LOAD: begin
            w_accum_nxt[i] = ACCUM_WIDTH'(r_operand[i]);
            w_ovf_nxt[i]   = 1'b0;
          end
          default: begin
            w_accum_nxt[i] = '0;
            w_ovf_nxt[i]   = 1'b0;
          end
        endcase
      end
    end
  end

  // Lane state and op counter commit on the EXEC->DONE edge only
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < NUM_LANES; i++) r_accum[i] <= '0;
      r_ovf      <= '0;
      r_op_count <= '0;
    end else if (r_state == S_EXEC) begin
      for (int i = 0; i < NUM_LANES; i++) r_accum[i] <= w_accum_nxt[i];
      r_ovf      <= w_ovf_nxt;
      r_op_count <= r_op_count + 16'd1;
    end
  end

  // Status flags registered from the next state so they track the FSM exactly
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  assign accum    = r_accum;
  assign ovf      = r_ovf;
  assign busy     = r_busy;
  assign done     = r_done;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_accum_array.sv
// Directed bench for accum_array: a default-width instance plus 16-bit wrap and
// saturate instances, all driven by the same handshake and operands.
module tb_accum_array;

  logic        clk;
  logic        reset_l;
  logic        req;
  logic [1:0]  op;
  logic [3:0]  lane_mask;
  logic [15:0] operand [4];

  logic [31:0] acc_d [4];
  logic [15:0] acc_w [4];
  logic [15:0] acc_s [4];
  logic [3:0]  ovf_d, ovf_w, ovf_s;
  logic        busy_d, busy_w, busy_s;
  logic        done_d, done_w, done_s;
  logic [15:0] cnt_d, cnt_w, cnt_s;

  int n_checks;
  int n_errors;
  int exp_cnt;

  accum_array u_dut (
    .clk(clk), .reset_l(reset_l), .req(req), .op(op), .lane_mask(lane_mask),
    .operand(operand), .accum(acc_d), .ovf(ovf_d), .busy(busy_d), .done(done_d),
    .op_count(cnt_d)
  );

  accum_array #(.NUM_LANES(4), .ACCUM_WIDTH(16), .ADD_WIDTH(16), .SATURATE(0)) u_wrap (
    .clk(clk), .reset_l(reset_l), .req(req), .op(op), .lane_mask(lane_mask),
    .operand(operand), .accum(acc_w), .ovf(ovf_w), .busy(busy_w), .done(done_w),
    .op_count(cnt_w)
  );

  accum_array #(.NUM_LANES(4), .ACCUM_WIDTH(16), .ADD_WIDTH(16), .SATURATE(1)) u_sat (
    .clk(clk), .reset_l(reset_l), .req(req), .op(op), .lane_mask(lane_mask),
    .operand(operand), .accum(acc_s), .ovf(ovf_s), .busy(busy_s), .done(done_s),
    .op_count(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d(input string tag, input logic [31:0] e0, e1, e2, e3);
    check({tag, "_d0"}, 64'(acc_d[0]), 64'(e0));
    check({tag, "_d1"}, 64'(acc_d[1]), 64'(e1));
    check({tag, "_d2"}, 64'(acc_d[2]), 64'(e2));
    check({tag, "_d3"}, 64'(acc_d[3]), 64'(e3));
  endtask

  // One full handshake; req held 'hold' extra cycles after done rises
  task automatic do_op(input string tag, input logic [1:0] o, input logic [3:0] m,
                       input logic [15:0] a0, a1, a2, a3, input int hold);
    op = o; lane_mask = m;
    operand[0] = a0; operand[1] = a1; operand[2] = a2; operand[3] = a3;
    req = 1'b1;
    tick();
    check({tag, "_exec_busy"}, 64'(busy_d), 64'd1);
    check({tag, "_exec_done"}, 64'(done_d), 64'd0);
    tick();
    exp_cnt++;
    check({tag, "_done"}, 64'(done_d), 64'd1);
    check({tag, "_cnt"}, 64'(cnt_d), 64'(exp_cnt));
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_hold_done"}, 64'(done_d), 64'd1);
      check({tag, "_hold_cnt"}, 64'(cnt_d), 64'(exp_cnt));
    end
    req = 1'b0;
    tick();
    check({tag, "_idle_done"}, 64'(done_d), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy_d), 64'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; exp_cnt = 0;
    reset_l = 1'b0; req = 1'b0; op = 2'b00; lane_mask = 4'h0;
    for (int i = 0; i < 4; i++) operand[i] = 16'h0;
    repeat (3) tick();
    reset_l = 1'b1;
    tick();

    // reset values
    chk_d("rst", 32'h0, 32'h0, 32'h0, 32'h0);
    check("rst_ovf", 64'(ovf_d), 64'h0);
    check("rst_busy", 64'(busy_d), 64'd0);
    check("rst_done", 64'(done_d), 64'd0);
    check("rst_cnt", 64'(cnt_d), 64'd0);

    // basic ADD twice
    do_op("add1", 2'b00, 4'hF, 16'h1, 16'h2, 16'h3, 16'hFFFF, 0);
    chk_d("add1", 32'h1, 32'h2, 32'h3, 32'hFFFF);
    do_op("add2", 2'b00, 4'hF, 16'h1, 16'h2, 16'h3, 16'hFFFF, 0);
    chk_d("add2", 32'h2, 32'h4, 32'h6, 32'h1FFFE);
    check("add2_ovf_d", 64'(ovf_d), 64'h0);
    check("add2_w3", 64'(acc_w[3]), 64'hFFFE);
    check("add2_ovf_w", 64'(ovf_w), 64'h8);
    check("add2_s3", 64'(acc_s[3]), 64'hFFFF);
    check("add2_ovf_s", 64'(ovf_s), 64'h8);

    // masked LOAD
    do_op("load5", 2'b10, 4'h5, 16'h10, 16'h20, 16'h30, 16'h40, 0);
    chk_d("load5", 32'h10, 32'h4, 32'h30, 32'h1FFFE);
    check("load5_ovf_w", 64'(ovf_w), 64'h8);

    // CLEAR all lanes clears sticky flags
    do_op("clrF", 2'b11, 4'hF, 16'h0, 16'h0, 16'h0, 16'h0, 0);
    chk_d("clrF", 32'h0, 32'h0, 32'h0, 32'h0);
    check("clrF_ovf_w", 64'(ovf_w), 64'h0);
    check("clrF_ovf_s", 64'(ovf_s), 64'h0);

    // wrap vs saturate on ADD
    do_op("ldfff0", 2'b10, 4'h1, 16'hFFF0, 16'h0, 16'h0, 16'h0, 0);
    do_op("add20", 2'b00, 4'h1, 16'h0020, 16'h0, 16'h0, 16'h0, 0);
    check("add20_d0", 64'(acc_d[0]), 64'h10010);
    check("add20_ovf_d", 64'(ovf_d), 64'h0);
    check("add20_w0", 64'(acc_w[0]), 64'h0010);
    check("add20_ovf_w", 64'(ovf_w), 64'h1);
    check("add20_s0", 64'(acc_s[0]), 64'hFFFF);
    check("add20_ovf_s", 64'(ovf_s), 64'h1);

    // SUB underflow from zero, then CLEAR
    do_op("clr1", 2'b11, 4'h1, 16'h0, 16'h0, 16'h0, 16'h0, 0);
    check("clr1_ovf_w", 64'(ovf_w), 64'h0);
    do_op("sub1", 2'b01, 4'h1, 16'h1, 16'h0, 16'h0, 16'h0, 0);
    check("sub1_d0", 64'(acc_d[0]), 64'hFFFFFFFF);
    check("sub1_ovf_d", 64'(ovf_d), 64'h1);
    check("sub1_w0", 64'(acc_w[0]), 64'hFFFF);
    check("sub1_ovf_w", 64'(ovf_w), 64'h1);
    check("sub1_s0", 64'(acc_s[0]), 64'h0);
    check("sub1_ovf_s", 64'(ovf_s), 64'h1);
    do_op("clr1b", 2'b11, 4'h1, 16'h0, 16'h0, 16'h0, 16'h0, 0);
    check("clr1b_ovf_d", 64'(ovf_d), 64'h0);
    check("clr1b_ovf_w", 64'(ovf_w), 64'h0);
    check("clr1b_ovf_s", 64'(ovf_s), 64'h0);
    check("clr1b_d0", 64'(acc_d[0]), 64'h0);

    // empty mask still counts
    do_op("mask0", 2'b00, 4'h0, 16'h1, 16'h1, 16'h1, 16'h1, 0);
    chk_d("mask0", 32'h0, 32'h0, 32'h0, 32'h0);

    // req held past done: no second update
    do_op("hold", 2'b00, 4'h2, 16'h0, 16'h5, 16'h0, 16'h0, 5);
    chk_d("hold", 32'h0, 32'h5, 32'h0, 32'h0);

    // req dropped during EXEC: one-cycle done, single update
    op = 2'b00; lane_mask = 4'h2; operand[1] = 16'h5;
    req = 1'b1;
    tick();
    check("early_busy", 64'(busy_d), 64'd1);
    req = 1'b0;
    tick();
    exp_cnt++;
    check("early_done", 64'(done_d), 64'd1);
    tick();
    check("early_done_fall", 64'(done_d), 64'd0);
    check("early_busy_fall", 64'(busy_d), 64'd0);
    tick();
    check("early_cnt", 64'(cnt_d), 64'(exp_cnt));
    chk_d("early", 32'h0, 32'hA, 32'h0, 32'h0);

    // reset asserted during EXEC
    op = 2'b00; lane_mask = 4'hF;
    for (int i = 0; i < 4; i++) operand[i] = 16'h7;
    req = 1'b1;
    tick();
    check("rmid_busy", 64'(busy_d), 64'd1);
    reset_l = 1'b0;
    #1;
    chk_d("rmid", 32'h0, 32'h0, 32'h0, 32'h0);
    check("rmid_cnt", 64'(cnt_d), 64'd0);
    check("rmid_busy0", 64'(busy_d), 64'd0);
    check("rmid_done0", 64'(done_d), 64'd0);
    check("rmid_ovf", 64'(ovf_d), 64'h0);
    tick();
    req = 1'b0;
    reset_l = 1'b1;
    tick();
    tick();
    chk_d("rpost", 32'h0, 32'h0, 32'h0, 32'h0);
    check("rpost_cnt", 64'(cnt_d), 64'd0);
    check("rpost_done", 64'(done_d), 64'd0);
    exp_cnt = 0;
    do_op("after_rst", 2'b00, 4'hF, 16'h1, 16'h1, 16'h1, 16'h1, 0);
    chk_d("after_rst", 32'h1, 32'h1, 32'h1, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
